// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between a traffic light controller and its monitor.
// The master side drives the observed light and sensor; the slave reports the tracked state.
interface traffic_light_monitor_if;
    logic [1:0] light;
    logic       sensor;
    logic       clear;
    logic [1:0] phase;
    logic [7:0] phase_cnt;
    logic       err;
    logic [2:0] err_code;
    logic       change;
    logic       cycle_done;
    logic [7:0] cycles;

    modport master (
        output light, sensor, clear,
        input  phase, phase_cnt, err, err_code, change, cycle_done, cycles
    );

    modport slave (
        input  light, sensor, clear,
        output phase, phase_cnt, err, err_code, change, cycle_done, cycles
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker that tracks a RED->GREEN->YELLOW light controller, timing each phase
// and flagging invalid codes, out-of-order phases, short dwells and sensor starvation.
module traffic_light_monitor #(
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MIN_RED    = 2,
    parameter int MAX_WAIT   = 32
) (
    input logic                     clk,
    input logic                     reset,
    traffic_light_monitor_if.slave  bus
);
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_RED    = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10,
        S_UNSYNC = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_INVALID = 3'd1,
        E_ILLEGAL = 3'd2,
        E_SHORT   = 3'd3,
        E_STARVE  = 3'd4
    } err_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    err_t          code_q, code_d;
    logic          change_q, change_d;
    logic          done_q, done_d;
    logic [7:0]    cycles_q, cycles_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          starved_q, starved_d;

    state_t        succ;
    logic [7:0]    min_cnt;
    err_t          trans_err;
    err_t          new_err;
    logic          starve;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_UNSYNC;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            code_q    <= E_NONE;
            change_q  <= 1'b0;
            done_q    <= 1'b0;
            cycles_q  <= '0;
            wait_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
            change_q  <= change_d;
            done_q    <= done_d;
            cycles_q  <= cycles_d;
            wait_q    <= wait_d;
            starved_q <= starved_d;
        end
    end

    always_comb begin
        succ    = S_RED;
        min_cnt = '0;
        case (state_q)
            S_RED:    begin succ = S_GREEN;  min_cnt = 8'(MIN_RED);    end
            S_GREEN:  begin succ = S_YELLOW; min_cnt = 8'(MIN_GREEN);  end
            S_YELLOW: begin succ = S_RED;    min_cnt = 8'(MIN_YELLOW); end
            default:  begin succ = S_RED;    min_cnt = '0;             end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        change_d  = 1'b0;
        done_d    = 1'b0;
        cycles_d  = cycles_q;
        trans_err = E_NONE;

        if (bus.light == 2'b11) begin
            trans_err = E_INVALID;
            state_d   = S_UNSYNC;
            cnt_d     = '0;
        end else if (state_q == S_UNSYNC) begin
            // Only a RED sample gives a trustworthy phase boundary to lock on to.
            if (bus.light == S_RED) begin
                state_d = S_RED;
                cnt_d   = 8'd1;
            end
        end else if (bus.light == state_q) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else if (bus.light == succ) begin
            state_d = succ;
            cnt_d   = 8'd1;
            if (cnt_q >= min_cnt) begin
                change_d = 1'b1;
                if (succ == S_RED) begin
                    done_d   = 1'b1;
                    cycles_d = cycles_q + 8'd1;
                end
            end else begin
                trans_err = E_SHORT;
            end
        end else begin
            trans_err = E_ILLEGAL;
            state_d   = state_t'(bus.light);
            cnt_d     = 8'd1;
        end
    end

    // Wait tracking follows the phase being entered, so the first RED sample already counts.
    always_comb begin
        wait_d    = '0;
        starve    = 1'b0;
        starved_d = 1'b0;
        if (state_d == S_RED) begin
            if (bus.sensor)
                wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
            starve    = bus.sensor && (wait_d == WW'(MAX_WAIT)) && !starved_q;
            starved_d = starved_q | starve;
        end
    end

    always_comb begin
        err_d   = err_q;
        code_d  = code_q;
        new_err = (trans_err != E_NONE) ? trans_err : (starve ? E_STARVE : E_NONE);
        if (new_err != E_NONE) begin
            err_d = 1'b1;
            if (!err_q || bus.clear)
                code_d = new_err;
        end else if (bus.clear) begin
            err_d  = 1'b0;
            code_d = E_NONE;
        end
    end

    assign bus.phase      = state_q;
    assign bus.phase_cnt  = cnt_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;
    assign bus.change     = change_q;
    assign bus.cycle_done = done_q;
    assign bus.cycles     = cycles_q;
endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4, meaning minimum legal GREEN dwell in cycles.
REQ-002 The block SHALL have parameter MIN_YELLOW, default 2, meaning minimum legal YELLOW dwell in cycles.
REQ-003 The block SHALL have parameter MIN_RED, default 2, meaning minimum legal RED dwell in cycles.
REQ-004 The block SHALL have parameter MAX_WAIT, default 32, meaning maximum RED cycles with sensor high before starvation.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 light  input  2  controller light code: 00 RED, 01 GREEN, 10 YELLOW, 11 invalid.
REQ-008 sensor  input  1  vehicle-waiting input, same signal the controller sees.
REQ-009 clear  input  1  clears sticky error when high at a rising edge.
REQ-010 phase  output  2  tracked phase, same code as light; 11 = UNSYNC.
REQ-011 phase_cnt  output  8  cycles spent in current phase, saturating at 255.
REQ-012 err  output  1  sticky error flag.
REQ-013 err_code  output  3  first error since last clear: 0 none, 1 INVALID, 2 ILLEGAL_SEQ, 3 SHORT_PHASE, 4 STARVATION.
REQ-014 change  output  1  one-cycle pulse on each legal, duration-compliant phase transition.
REQ-015 cycle_done  output  1  one-cycle pulse on each legal YELLOW->RED transition.
REQ-016 cycles  output  8  count of cycle_done pulses, wraps 255->0.

Function
REQ-017 The block SHALL sample light every rising edge; all outputs SHALL be registered and reflect the sample taken at that edge (one-cycle latency from light change).
REQ-018 The FSM SHALL have states UNSYNC, RED, GREEN, YELLOW; legal sequence RED->GREEN->YELLOW->RED.
REQ-019 In UNSYNC, light=RED SHALL move to RED with phase_cnt=1; light=GREEN/YELLOW SHALL stay UNSYNC, phase_cnt=0, no error.
REQ-020 In a tracked state, light equal to the state SHALL saturating-increment phase_cnt.
REQ-021 light equal to the legal successor with phase_cnt >= MIN of the current phase SHALL move to the successor, set phase_cnt=1, and pulse change.
REQ-022 light equal to the legal successor with phase_cnt < MIN SHALL raise SHORT_PHASE, move to the successor, set phase_cnt=1, no change pulse.
REQ-023 light equal to a tracked phase other than current or successor SHALL raise ILLEGAL_SEQ, resync to the observed phase, set phase_cnt=1, no change pulse.
REQ-024 light=11 in any state SHALL raise INVALID, go to UNSYNC, set phase_cnt=0.
REQ-025 cycle_done SHALL pulse only with a change pulse for YELLOW->RED; cycles SHALL increment on the same edge.
REQ-026 A wait counter SHALL increment each cycle the state is RED and sensor is high, and SHALL clear when sensor is low or state leaves RED.
REQ-027 STARVATION SHALL be raised on the edge the wait counter reaches MAX_WAIT, once per RED dwell.
REQ-028 On error raise with err low, err SHALL go high and err_code SHALL latch the code; with err already high, err_code SHALL be unchanged.
REQ-029 clear SHALL set err=0, err_code=0; an error raised on the same edge SHALL win (err=1, new code latched).
REQ-030 Only one of INVALID/ILLEGAL_SEQ/SHORT_PHASE can arise per edge; if STARVATION coincides with one, the transition error SHALL take priority.

Reset
REQ-031 reset high at a rising edge SHALL force UNSYNC, phase=11, phase_cnt=0, err=0, err_code=0, change=0, cycle_done=0, cycles=0, wait counter=0, overriding clear and light.
REQ-032 reset asserted mid-phase SHALL discard all history; tracking resumes only at the next RED sample after reset deasserts.

Verification
REQ-033 Reset, then light RED 2, GREEN 4, YELLOW 2, RED -> change pulses at 3 transitions, cycle_done once, cycles=1, err=0.
REQ-034 RED 5 cycles then GREEN 2 then YELLOW -> err=1, err_code=3, phase=YELLOW, phase_cnt=1.
REQ-035 RED 3 cycles then YELLOW -> err_code=2, phase=YELLOW; later light=11 -> err_code stays 2, phase=11.
REQ-036 RED with sensor high 32 cycles -> err_code=4 on the 32nd sample; sensor drop at cycle 31 then high again -> no error until 32 further cycles.
REQ-037 Sticky error present, clear and a new SHORT_PHASE on same edge -> err=1, err_code=3; clear alone next edge -> err=0, err_code=0.
REQ-038 GREEN held 300 cycles -> phase_cnt saturates at 255; 256 legal full cycles -> cycles wraps to 0.
